// File: rtl/charmap_writer.sv
// Character-map write engine: byte stream in, cursor tracking, screen clear, character RAM writes.
// Optional: define CHARMAP_WRITER_CLRLINE_EN to blank each new row entered via LF or end-of-row wrap.
module charmap_writer #(
  parameter int          COLS       = 64,
  parameter int          ROWS       = 32,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        clear_req,
  output logic        busy,
  output logic [11:0] chram_addr,
  output logic [7:0]  chram_din,
  output logic        chram_wr,
  output logic [5:0]  cursor_x,
  output logic [5:0]  cursor_y
);

`ifdef CHARMAP_WRITER_CLRLINE_EN
  typedef enum logic [2:0] {IDLE, ESC_X, ESC_Y, CLEAR, CLRLINE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ESC_X, ESC_Y, CLEAR} state_t;
`endif

  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);

  state_t      state_q, state_d;
  logic [5:0]  cx_q, cx_d, cy_q, cy_d;
  logic [5:0]  clr_col_q, clr_col_d, clr_row_q, clr_row_d;
  logic        wr_q, wr_d, busy_q, busy_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        accept, start_clear;
  logic [5:0]  next_row;

  assign in_ready = (state_q == IDLE || state_q == ESC_X || state_q == ESC_Y)
                    && !clear_req && !reset;
  assign accept   = in_valid && in_ready;
  assign next_row = (cy_q == ROW_MAX) ? 6'd0 : cy_q + 6'd1;

  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    clr_col_d   = clr_col_q;
    clr_row_d   = clr_row_q;
    wr_d        = 1'b0;
    busy_d      = busy_q;
    addr_d      = addr_q;
    din_d       = din_q;
    start_clear = clear_req && (state_q != CLEAR);

    case (state_q)
      IDLE: if (accept) begin
        case (in_data)
          8'h0A: begin
            cx_d = 6'd0;
            cy_d = next_row;
`ifdef CHARMAP_WRITER_CLRLINE_EN
            state_d   = CLRLINE;
            busy_d    = 1'b1;
            clr_row_d = next_row;
            clr_col_d = 6'd0;
`endif
          end
          8'h0D: cx_d = 6'd0;
          8'h08: if (cx_q != 6'd0) cx_d = cx_q - 6'd1;
          8'h0C: start_clear = 1'b1;
          8'h1B: state_d = ESC_X;
          default: begin
            wr_d   = 1'b1;
            addr_d = {cy_q, cx_q};
            din_d  = in_data;
            if (cx_q == COL_MAX) begin
              cx_d = 6'd0;
              cy_d = next_row;
`ifdef CHARMAP_WRITER_CLRLINE_EN
              state_d   = CLRLINE;
              busy_d    = 1'b1;
              clr_row_d = next_row;
              clr_col_d = 6'd0;
`endif
            end else begin
              cx_d = cx_q + 6'd1;
            end
          end
        endcase
      end
      ESC_X: if (accept) begin
        cx_d    = (in_data > {2'b00, COL_MAX}) ? COL_MAX : in_data[5:0];
        state_d = ESC_Y;
      end
      ESC_Y: if (accept) begin
        cy_d    = (in_data > {2'b00, ROW_MAX}) ? ROW_MAX : in_data[5:0];
        state_d = IDLE;
      end
      CLEAR: begin
        wr_d   = 1'b1;
        addr_d = {clr_row_q, clr_col_q};
        din_d  = CLEAR_CHAR;
        if (clr_col_q == COL_MAX) begin
          clr_col_d = 6'd0;
          if (clr_row_q == ROW_MAX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cx_d    = 6'd0;
            cy_d    = 6'd0;
          end else begin
            clr_row_d = clr_row_q + 6'd1;
          end
        end else begin
          clr_col_d = clr_col_q + 6'd1;
        end
      end
`ifdef CHARMAP_WRITER_CLRLINE_EN
      CLRLINE: begin
        wr_d   = 1'b1;
        addr_d = {clr_row_q, clr_col_q};
        din_d  = CLEAR_CHAR;
        if (clr_col_q == COL_MAX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_col_d = clr_col_q + 6'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A clear request overrides anything decoded above, including a line clear in flight.
    if (start_clear) begin
      state_d   = CLEAR;
      busy_d    = 1'b1;
      clr_row_d = 6'd0;
      clr_col_d = 6'd0;
      wr_d      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cx_q      <= 6'd0;
      cy_q      <= 6'd0;
      clr_col_q <= 6'd0;
      clr_row_q <= 6'd0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= 12'd0;
      din_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  assign chram_wr   = wr_q;
  assign chram_addr = addr_q;
  assign chram_din  = din_q;
  assign busy       = busy_q;
  assign cursor_x   = cx_q;
  assign cursor_y   = cy_q;

endmodule

// File: tb/tb_charmap_writer.sv
// Scoreboard bench for charmap_writer (default build): a cursor model predicts every RAM write.
module tb_charmap_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear_req;
  logic        busy;
  logic [11:0] chram_addr;
  logic [7:0]  chram_din;
  logic        chram_wr;
  logic [5:0]  cursor_x, cursor_y;

  charmap_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clear_req(clear_req), .busy(busy), .chram_addr(chram_addr), .chram_din(chram_din),
    .chram_wr(chram_wr), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int wr_cnt = 0, busy_cnt = 0;
  logic [19:0] sb[$];          // {addr, data}
  logic [5:0]  mx = 0, my = 0;  // model cursor (col, row)
  int          esc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_clear();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) sb.push_back({6'(r), 6'(c), 8'h20});
    mx = 0; my = 0; esc = 0;
  endtask

  // Reference cursor model; returns whether the byte produces a write next cycle.
  task automatic model(input logic [7:0] b, output bit writes);
    logic [5:0] nr;
    writes = 0;
    nr = (my == 6'd31) ? 6'd0 : my + 6'd1;
    if (esc == 1) begin
      mx = (b > 8'd63) ? 6'd63 : b[5:0]; esc = 2;
    end else if (esc == 2) begin
      my = (b > 8'd31) ? 6'd31 : b[5:0]; esc = 0;
    end else begin
      case (b)
        8'h0A: begin mx = 0; my = nr; end
        8'h0D: mx = 0;
        8'h08: if (mx != 0) mx = mx - 6'd1;
        8'h0C: push_clear();
        8'h1B: esc = 1;
        default: begin
          sb.push_back({my, mx, b});
          writes = 1;
          if (mx == 6'd63) begin mx = 0; my = nr; end
          else mx = mx + 6'd1;
        end
      endcase
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int waited);
    bit w;
    waited = 0;
    in_valid = 1'b1; in_data = b;
    #3;
    while (!in_ready && waited < 4000) begin @(posedge clk); #4; waited++; end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      w = 0;
    end else model(b, w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("wr_latency", {31'd0, chram_wr}, {31'd0, w});
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, {26'd0, cursor_x}, {26'd0, mx});
    check({tag, "_y"}, {26'd0, cursor_y}, {26'd0, my});
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 4000) begin @(posedge clk); #1; t++; end
    check("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (chram_wr) begin
        logic [19:0] e;
        wr_cnt++;
        if (sb.size() == 0) check("unexpected_wr", {20'd0, chram_addr}, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("wr_addr", {20'd0, chram_addr}, {20'd0, e[19:8]});
          check("wr_data", {24'd0, chram_din}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, b0, base, t;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear_req = 1'b0;
    #12;
    check("rst_wr", {31'd0, chram_wr}, 0);
    check("rst_addr", {20'd0, chram_addr}, 0);
    check("rst_din", {24'd0, chram_din}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, in_ready}, 0);
    check_cursor("rst_cur");
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back printable bytes
    send_byte(8'h48, w); check("ready_h", w, 0);
    send_byte(8'h69, w); check("ready_i", w, 0);
    drain(); check_cursor("hi");

    // Escape to bottom-right corner, then wrap
    send_byte(8'h1B, w); send_byte(8'd63, w); send_byte(8'd31, w);
    send_byte(8'h5A, w);
    drain(); check_cursor("wrap");

    // Clamped escape coordinates
    send_byte(8'h1B, w); send_byte(8'd200, w); send_byte(8'd200, w);
    check_cursor("clamp");

    // Control codes from (row 5, col 10)
    send_byte(8'h1B, w); send_byte(8'd10, w); send_byte(8'd5, w);
    send_byte(8'h08, w); check_cursor("bs");
    send_byte(8'h0D, w); check_cursor("cr");
    send_byte(8'h08, w); check_cursor("bs0");
    send_byte(8'h0A, w); check_cursor("lf");

    // clear_req colliding with a valid byte: clear wins, byte held
    clear_req = 1'b1; in_valid = 1'b1; in_data = 8'h41;
    #3 check("ready_vs_clear", {31'd0, in_ready}, 0);
    push_clear();
    b0 = busy_cnt;
    @(posedge clk); #1 clear_req = 1'b0;
    check("busy_start", {31'd0, busy}, 1);
    send_byte(8'h41, w);
    check("busy_cycles", busy_cnt - b0, 2048);
    drain(); check_cursor("after_clear");

    // Form-feed clear; clear_req mid-clear must not restart it; reset after 100 writes
    send_byte(8'h0C, w);
    base = wr_cnt; t = 0;
    while (wr_cnt - base < 50 && t < 500) begin @(posedge clk); #1; t++; end
    clear_req = 1'b1; @(posedge clk); #1 clear_req = 1'b0;
    while (wr_cnt - base < 100 && t < 500) begin @(posedge clk); #1; t++; end
    check("clear_progress", {31'd0, (wr_cnt - base >= 100)}, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_wr", {31'd0, chram_wr}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_ready", {31'd0, in_ready}, 0);
    check("mid_rst_addr", {20'd0, chram_addr}, 0);
    check("mid_rst_din", {24'd0, chram_din}, 0);
    sb.delete(); mx = 0; my = 0; esc = 0;
    check_cursor("mid_rst_cur");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    send_byte(8'h41, w);
    drain(); check_cursor("post_rst");

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
